// File: rtl/riscv_defs.sv
// Shared fetch-stage definitions: FSM encoding, word widths, reset address, buffer entry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_defs;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned INSTR_W = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  // One fetch-buffer entry: instruction word tagged with its own address.
  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Force an address onto a 4-byte boundary.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Synchronous FIFO of {pc,instr} entries with single-cycle flush.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: push into a full buffer is only honoured together with a pop; pop on empty is ignored.
module fetch_buffer
  import riscv_defs::*;
#(
  parameter int unsigned DEPTH = 3
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  fetch_entry_t                 push_dat_i,
  input  logic                         pop_i,
  output fetch_entry_t                 head_dat_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  fetch_entry_t    mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            do_push, do_pop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

  // Entry storage; contents need no reset because the head is qualified by occupancy.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

  // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_next(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_next(rd_ptr_q);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  assign head_dat_o = mem_q[rd_ptr_q];
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;

endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch: PC sequencing, memory request issue, in-order response buffering, redirect drain.
// Latency: with a 1-cycle memory, an accepted fetch reaches the buffer head two cycles later.
// Backpressure: requests stop once in-flight plus buffered entries reach BUF_DEPTH; STALL holds the head.
module pc_fetch
  import riscv_defs::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int unsigned BUF_DEPTH = 3
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        stall_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic [31:0] pc_plusfour_o
);

  localparam int unsigned CW = $clog2(BUF_DEPTH+1);

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;   // address of the oldest outstanding request
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] buf_count;
  logic [CW:0]   in_use;
  logic [31:0]   redirect_tgt;
  logic          buf_empty, accept, rsp_ok, rsp_keep, deq;
  fetch_entry_t  head, enq_dat;

  assign redirect_tgt = word_align(redirect_pc_i);

  // Issue decision uses registered counts only, so REQ cannot drop before it is accepted.
  assign in_use      = {1'b0, outst_q} + {1'b0, buf_count};
  assign imem_req_o  = !reset_i && (state_q == ST_FETCH) && (in_use < (CW+1)'(BUF_DEPTH));
  assign imem_addr_o = reset_i ? RESET_PC : pc_q;
  assign accept      = imem_req_o && imem_ready_i;

  // A response only counts if something is actually outstanding; strays are ignored.
  assign rsp_ok   = !reset_i && (state_q == ST_FETCH) && imem_rvalid_i && (outst_q != '0);
  assign rsp_keep = rsp_ok && !redirect_i;
  assign enq_dat  = '{pc: resp_pc_q, instr: imem_rdata_i};

  assign instr_valid_o = !reset_i && !buf_empty;
  assign deq           = instr_valid_o && !stall_i && !redirect_i;
  assign instr_o       = instr_valid_o ? head.instr : '0;
  assign instr_pc_o    = instr_valid_o ? head.pc : '0;
  assign pc_plusfour_o = instr_pc_o + 32'd4;

  fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .flush_i    (redirect_i),
    .push_i     (rsp_keep),
    .push_dat_i (enq_dat),
    .pop_i      (deq),
    .head_dat_o (head),
    .empty_o    (buf_empty),
    .count_o    (buf_count)
  );

  // Next-state: PC advance, outstanding/drop accounting and redirect handling.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    resp_pc_d = resp_pc_q;
    outst_d   = outst_q;
    drop_d    = drop_q;
    unique case (state_q)
      ST_BOOT: begin
        state_d = ST_FETCH;
        if (redirect_i) begin
          pc_d      = redirect_tgt;
          resp_pc_d = redirect_tgt;
        end
      end
      ST_FETCH: begin
        if (accept)   pc_d      = pc_q + 32'd4;
        if (rsp_keep) resp_pc_d = resp_pc_q + 32'd4;
        outst_d = outst_q + CW'(accept) - CW'(rsp_ok);
        if (redirect_i) begin
          // Everything still in flight belongs to the wrong path and must be swallowed.
          pc_d      = redirect_tgt;
          resp_pc_d = redirect_tgt;
          outst_d   = '0;
          drop_d    = outst_q + CW'(accept) - CW'(rsp_ok);
          if (drop_d != '0) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (imem_rvalid_i && (drop_q != '0)) drop_d = drop_q - CW'(1);
        if (redirect_i) begin
          pc_d      = redirect_tgt;
          resp_pc_d = redirect_tgt;
        end
        if (drop_d == '0) state_d = ST_FETCH;
      end
      default: state_d = ST_BOOT;
    endcase
  end

  // State registers with synchronous reset; reset abandons all in-flight traffic.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ST_BOOT;
      pc_q      <= RESET_PC;
      resp_pc_q <= RESET_PC;
      outst_q   <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      resp_pc_q <= resp_pc_d;
      outst_q   <= outst_d;
      drop_q    <= drop_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: per-cycle vector table plus multi-cycle sequences.
// Latency: memory model answers in-order a configurable number of cycles after acceptance.
// Backpressure: READY and STALL driven by the vectors or pseudo-randomly.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst, redirect, stall, ready, rvalid;
  logic [31:0] redirect_pc, rdata;
  logic        req, ivalid;
  logic [31:0] addr, instr, ipc, p4;

  always #5 clk = ~clk;

  pc_fetch #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(3)) dut (
    .clk_i         (clk),
    .reset_i       (rst),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .stall_i       (stall),
    .imem_req_o    (req),
    .imem_addr_o   (addr),
    .imem_ready_i  (ready),
    .imem_rvalid_i (rvalid),
    .imem_rdata_i  (rdata),
    .instr_valid_o (ivalid),
    .instr_o       (instr),
    .instr_pc_o    (ipc),
    .pc_plusfour_o (p4)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int lat      = 1;
  int n_acc    = 0;

  logic [31:0] q_addr[$];
  int          q_due[$];
  logic [31:0] dv_pc[$], dv_ins[$], dv_p4[$];

  logic        s_req, s_valid;
  logic [31:0] s_addr, s_instr, s_ipc, s_p4;

  function automatic logic [31:0] ins_of(input logic [31:0] a);
    return a ^ 32'hC0DE_1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: drive memory response, sample outputs mid-cycle, update models.
  task automatic tick();
    if (rst) begin
      q_addr.delete();
      q_due.delete();
    end
    if (!rst && q_due.size() > 0 && q_due[0] <= cyc) begin
      rvalid = 1'b1;
      rdata  = ins_of(q_addr[0]);
      void'(q_addr.pop_front());
      void'(q_due.pop_front());
    end else begin
      rvalid = 1'b0;
      rdata  = '0;
    end
    #4;
    s_req = req; s_addr = addr; s_valid = ivalid;
    s_instr = instr; s_ipc = ipc; s_p4 = p4;
    if (s_req && ready && !rst) begin
      q_addr.push_back(s_addr);
      q_due.push_back(cyc + lat);
      n_acc++;
    end
    if (s_valid && !stall && !redirect) begin
      dv_pc.push_back(s_ipc);
      dv_ins.push_back(s_instr);
      dv_p4.push_back(s_p4);
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic clear_dv();
    dv_pc.delete(); dv_ins.delete(); dv_p4.delete();
  endtask

  // Check that deliveries form an unbroken word-stride stream starting at base.
  task automatic chk_stream(input string name, input logic [31:0] base, input int min_n);
    chk({name, " count>=min"}, 32'(dv_pc.size() >= min_n), 32'd1);
    for (int i = 0; i < dv_pc.size(); i++) begin
      chk($sformatf("%s pc[%0d]", name, i), dv_pc[i], base + 32'(4*i));
      chk($sformatf("%s ins[%0d]", name, i), dv_ins[i], ins_of(base + 32'(4*i)));
    end
  endtask

  typedef struct {
    logic        rst, redir;
    logic [31:0] rpc;
    logic        stall;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] ipc;
  } vec_t;

  localparam int NV = 21;
  vec_t vt [NV];

  task automatic setv(input int i, input logic r, input logic rd, input logic [31:0] rp,
                      input logic st, input logic eq, input logic [31:0] ea,
                      input logic ev, input logic [31:0] ep);
    vt[i] = '{rst: r, redir: rd, rpc: rp, stall: st, req: eq, addr: ea, valid: ev, ipc: ep};
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //       rst rdr rpc            stl req addr           vld ipc
    setv( 0, 1, 0, 32'h0,         0, 0, 32'h0000_0000, 0, 32'h0);
    setv( 1, 0, 0, 32'h0,         0, 0, 32'h0000_0000, 0, 32'h0);
    setv( 2, 0, 0, 32'h0,         0, 1, 32'h0000_0000, 0, 32'h0);
    setv( 3, 0, 0, 32'h0,         0, 1, 32'h0000_0004, 0, 32'h0);
    setv( 4, 0, 0, 32'h0,         0, 1, 32'h0000_0008, 1, 32'h0);
    setv( 5, 0, 0, 32'h0,         0, 1, 32'h0000_000C, 1, 32'h4);
    setv( 6, 0, 0, 32'h0,         1, 1, 32'h0000_0010, 1, 32'h8);
    setv( 7, 0, 0, 32'h0,         1, 0, 32'h0000_0014, 1, 32'h8);
    setv( 8, 0, 0, 32'h0,         1, 0, 32'h0000_0014, 1, 32'h8);
    setv( 9, 0, 0, 32'h0,         0, 0, 32'h0000_0014, 1, 32'h8);
    setv(10, 0, 0, 32'h0,         0, 1, 32'h0000_0014, 1, 32'hC);
    setv(11, 0, 0, 32'h0,         0, 1, 32'h0000_0018, 1, 32'h10);
    setv(12, 0, 0, 32'h0,         0, 1, 32'h0000_001C, 1, 32'h14);
    setv(13, 0, 1, 32'h0000_0203, 1, 1, 32'h0000_0020, 1, 32'h18);
    setv(14, 0, 0, 32'h0,         0, 0, 32'h0000_0200, 0, 32'h0);
    setv(15, 0, 0, 32'h0,         0, 1, 32'h0000_0200, 0, 32'h0);
    setv(16, 0, 0, 32'h0,         0, 1, 32'h0000_0204, 0, 32'h0);
    setv(17, 0, 0, 32'h0,         0, 1, 32'h0000_0208, 1, 32'h200);
    setv(18, 1, 0, 32'h0,         0, 0, 32'h0000_0000, 0, 32'h0);
    setv(19, 0, 1, 32'h0000_0040, 0, 0, 32'h0000_0000, 0, 32'h0);
    setv(20, 0, 0, 32'h0,         0, 1, 32'h0000_0040, 0, 32'h0);

    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; stall = 1'b0;
    ready = 1'b1; rvalid = 1'b0; rdata = '0;
    @(posedge clk);
    #1;

    // Per-cycle vector table, 1-cycle memory, READY always high.
    lat = 1;
    for (int i = 0; i < NV; i++) begin
      rst = vt[i].rst; redirect = vt[i].redir; redirect_pc = vt[i].rpc;
      stall = vt[i].stall; ready = 1'b1;
      tick();
      chk($sformatf("v%0d req", i),   32'(s_req),   32'(vt[i].req));
      chk($sformatf("v%0d addr", i),  s_addr,       vt[i].addr);
      chk($sformatf("v%0d valid", i), 32'(s_valid), 32'(vt[i].valid));
      chk($sformatf("v%0d ipc", i),   s_ipc,        vt[i].ipc);
      chk($sformatf("v%0d instr", i), s_instr,      vt[i].valid ? ins_of(vt[i].ipc) : 32'h0);
      chk($sformatf("v%0d p4", i),    s_p4,         vt[i].ipc + 32'd4);
    end
    redirect = 1'b0; stall = 1'b0;

    // Stall held from reset release for 10 cycles: exactly three fetches fill the window.
    lat = 1; ready = 1'b1; stall = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; n_acc = 0; clear_dv();
    for (int k = 0; k < 10; k++) tick();
    chk("stall accepts", 32'(n_acc), 32'd3);
    chk("stall req low", 32'(s_req), 32'd0);
    stall = 1'b0;
    for (int k = 0; k < 12; k++) tick();
    chk_stream("stall release", 32'h0, 8);

    // Redirect with two requests in flight on a 3-cycle memory.
    lat = 3; ready = 1'b1; stall = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick();
    tick();
    ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0100;
    tick();
    chk("drain redirect req", 32'(s_req), 32'd1);
    chk("drain redirect addr", s_addr, 32'h0000_0008);
    redirect = 1'b0; ready = 1'b1; clear_dv();
    tick();
    chk("drain c1 req", 32'(s_req), 32'd0);
    chk("drain c1 addr", s_addr, 32'h0000_0100);
    chk("drain c1 valid", 32'(s_valid), 32'd0);
    tick();
    chk("drain c2 req", 32'(s_req), 32'd0);
    tick();
    chk("post drain req", 32'(s_req), 32'd1);
    chk("post drain addr", s_addr, 32'h0000_0100);
    for (int k = 0; k < 10 && dv_pc.size() == 0; k++) tick();
    chk("drain delivered", 32'(dv_pc.size() > 0), 32'd1);
    if (dv_pc.size() > 0) begin
      chk("drain first pc", dv_pc[0], 32'h0000_0100);
      chk("drain first ins", dv_ins[0], ins_of(32'h0000_0100));
    end

    // PC wrap across the top of the address space.
    lat = 1; ready = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8; clear_dv();
    tick();
    redirect = 1'b0;
    tick();
    chk("wrap addr0", s_addr, 32'hFFFF_FFF8);
    tick();
    chk("wrap addr1", s_addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap addr2", s_addr, 32'h0000_0000);
    for (int k = 0; k < 4; k++) tick();
    chk_stream("wrap stream", 32'hFFFF_FFF8, 3);
    if (dv_p4.size() > 1) chk("wrap p4", dv_p4[1], 32'h0000_0000);

    // Random READY/STALL, 3-cycle memory, then reset pulsed mid-stream.
    lat = 3; rst = 1'b1;
    tick();
    rst = 1'b0; clear_dv();
    for (int k = 0; k < 40; k++) begin
      ready = 1'($urandom_range(0, 1));
      stall = ($urandom_range(0, 3) == 0);
      tick();
    end
    chk_stream("random", 32'h0, 1);
    rst = 1'b1; stall = 1'b0; ready = 1'b1;
    tick();
    chk("rst req", 32'(s_req), 32'd0);
    chk("rst valid", 32'(s_valid), 32'd0);
    chk("rst addr", s_addr, 32'h0);
    chk("rst instr", s_instr, 32'h0);
    chk("rst ipc", s_ipc, 32'h0);
    chk("rst p4", s_p4, 32'h4);
    rst = 1'b0; clear_dv();
    tick();
    chk("boot req", 32'(s_req), 32'd0);
    chk("boot valid", 32'(s_valid), 32'd0);
    chk("boot addr", s_addr, 32'h0);
    for (int k = 0; k < 20; k++) tick();
    chk_stream("restart", 32'h0, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
